alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the board-level ALU.
- Takes operand/opcode transactions over a valid/ready handshake and computes in a 2-stage pipeline.
- Returns the result plus Zero/Negative/Carry/Overflow flags over a second valid/ready handshake.
- Sits between the operand-capture logic (switches/buttons or a UART front end) and the result sink (LEDS or TX).

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_datapath.sv | 70 +++++++
 rtl/alu_pipe.sv | 101 ++++++++++
 tb/tb_alu_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings (MIPS funct codes) and flag bit positions for the ALU pipeline.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SLT = 6'b101010;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result, {Z,N,C,V} flags and unknown-opcode indication.
module alu_datapath #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned N_OPS   = 6,
  parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic [N_OPS-1:0]  op_i,
  output logic [N_BITS-1:0] result_o,
  output logic [3:0]        flags_o,
  output logic              op_err_o
);
  import alu_pkg::*;

  logic [N_BITS:0]    sum;
  logic [N_BITS:0]    diff;
  logic [SH_BITS-1:0] sh;
  logic [N_BITS-1:0]  res;
  logic               carry;
  logic               ovf;
  logic               a_msb;
  logic               b_msb;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  // Bit N_BITS of the widened difference is the unsigned borrow.
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign sh    = b_i[SH_BITS-1:0];
  assign a_msb = a_i[N_BITS-1];
  assign b_msb = b_i[N_BITS-1];

  always_comb begin
    res      = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    op_err_o = 1'b0;
    case (op_i)
      N_OPS'(OP_ADD): begin
        res   = sum[N_BITS-1:0];
        carry = sum[N_BITS];
        ovf   = (a_msb == b_msb) && (sum[N_BITS-1] != a_msb);
      end
      N_OPS'(OP_SUB): begin
        res   = diff[N_BITS-1:0];
        carry = diff[N_BITS];
        ovf   = (a_msb != b_msb) && (diff[N_BITS-1] != a_msb);
      end
      N_OPS'(OP_AND): res = a_i & b_i;
      N_OPS'(OP_OR):  res = a_i | b_i;
      N_OPS'(OP_XOR): res = a_i ^ b_i;
      N_OPS'(OP_NOR): res = ~(a_i | b_i);
      N_OPS'(OP_SLL): res = a_i << sh;
      N_OPS'(OP_SRL): res = a_i >> sh;
      N_OPS'(OP_SRA): res = $unsigned($signed(a_i) >>> sh);
      N_OPS'(OP_SLT): res = {{(N_BITS-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:        op_err_o = 1'b1;
    endcase
  end

  always_comb begin
    flags_o        = '0;
    flags_o[FLG_Z] = (res == '0);
    flags_o[FLG_N] = res[N_BITS-1];
    flags_o[FLG_C] = carry;
    flags_o[FLG_V] = ovf;
  end

  assign result_o = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result/flags.
module alu_pipe #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned N_OPS   = 6,
  parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [N_BITS-1:0] Data_A,
  input  logic [N_BITS-1:0] Data_B,
  input  logic [N_OPS-1:0]  Op,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [N_BITS-1:0] Result,
  output logic [3:0]        Flags,
  output logic              Op_Err
);

  logic              s1_valid_q, s1_valid_d;
  logic [N_BITS-1:0] s1_a_q;
  logic [N_BITS-1:0] s1_b_q;
  logic [N_OPS-1:0]  s1_op_q;
  logic              s2_valid_q, s2_valid_d;
  logic [N_BITS-1:0] s2_result_q;
  logic [3:0]        s2_flags_q;
  logic              s2_err_q;

  logic              adv1, adv2;
  logic              s1_load, s2_load;
  logic [N_BITS-1:0] dp_result;
  logic [3:0]        dp_flags;
  logic              dp_err;

  // A stage may advance when it is empty or its successor is draining this cycle.
  assign adv2     = !s2_valid_q || Out_Ready;
  assign adv1     = !s1_valid_q || adv2;
  assign In_Ready = adv1;
  assign s1_load  = In_Valid && adv1;
  assign s2_load  = s1_valid_q && adv2;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (adv1) s1_valid_d = In_Valid;
    if (adv2) s2_valid_d = s1_valid_q;
  end

  alu_datapath #(
    .N_BITS  (N_BITS),
    .N_OPS   (N_OPS),
    .SH_BITS (SH_BITS)
  ) u_datapath (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (dp_result),
    .flags_o  (dp_flags),
    .op_err_o (dp_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_a_q  <= Data_A;
        s1_b_q  <= Data_B;
        s1_op_q <= Op;
      end
    end
  end

  // Result registers only load on a stage advance, so they hold while stalled or idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_err_q    <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_result_q <= dp_result;
        s2_flags_q  <= dp_flags;
        s2_err_q    <= dp_err;
      end
    end
  end

  assign Out_Valid = s2_valid_q;
  assign Result    = s2_result_q;
  assign Flags     = s2_flags_q;
  assign Op_Err    = s2_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, latency/throughput run, random backpressure, reset.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [7:0] Data_A = 8'h00;
  logic [7:0] Data_B = 8'h00;
  logic [5:0] Op = 6'h00;
  logic       Out_Valid;
  logic       Out_Ready = 1'b1;
  logic [7:0] Result;
  logic [3:0] Flags;
  logic       Op_Err;

  alu_pipe #(
    .N_BITS  (8),
    .N_OPS   (6),
    .SH_BITS (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Data_A    (Data_A),
    .Data_B    (Data_B),
    .Op        (Op),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result),
    .Flags     (Flags),
    .Op_Err    (Op_Err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    exp_t       exp;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       cur_exp = '0;
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         rand_ready = 1'b0;
  bit         ready_val = 1'b1;
  bit         lat_log = 1'b0;
  int         in_cycs[$];
  int         out_cycs[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_res = 8'h00;
  logic [3:0] prev_flg = 4'h0;
  logic       prev_err = 1'b0;
  vec_t       vecs[16];
  logic [5:0] op_pool[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                              input logic [7:0] res, input logic [3:0] flg, input logic err);
    vec_t v;
    v.a = a;
    v.b = b;
    v.op = op;
    v.exp.res = res;
    v.exp.flg = flg;
    v.exp.err = err;
    return v;
  endfunction

  // Reference behaviour written with integer arithmetic, independent of the RTL structure.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    exp_t       e;
    int         sa;
    int         sb;
    int         t;
    logic [7:0] r;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    r  = a;
    case (op)
      OP_ADD: begin
        t = int'(a) + int'(b);
        e.res = t[7:0];
        e.flg[1] = (t > 255);
        e.flg[0] = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      OP_SUB: begin
        t = int'(a) - int'(b);
        e.res = t[7:0];
        e.flg[1] = (a < b);
        e.flg[0] = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_NOR: e.res = ~(a | b);
      OP_SLL: e.res = a << b[2:0];
      OP_SRL: e.res = a >> b[2:0];
      OP_SRA: begin
        for (int i = 0; i < int'(b[2:0]); i++) r = {r[7], r[7:1]};
        e.res = r;
      end
      OP_SLT: e.res = (sa < sb) ? 8'h01 : 8'h00;
      default: e.err = 1'b1;
    endcase
    e.flg[3] = (e.res == 8'h00);
    e.flg[2] = e.res[7];
    return e;
  endfunction

  // Monitor: transfers are decided at the coming rising edge, sampled here mid-cycle.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(In_Ready), 32'((sb_q.size() < 2) || Out_Ready));
      if (Out_Valid && sb_q.size() == 0) chk("stale_out_valid", 32'(Out_Valid), 32'd0);
      if (prev_stall)
        chk("stall_hold", 32'({Out_Valid, Result, Flags, Op_Err}),
            32'({1'b1, prev_res, prev_flg, prev_err}));
      if (Out_Valid && Out_Ready && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("result", 32'({Result, Flags, Op_Err}), 32'(mon_e));
        if (lat_log) out_cycs.push_back(cyc);
      end
      if (In_Valid && In_Ready) begin
        sb_q.push_back(cur_exp);
        if (lat_log) in_cycs.push_back(cyc);
      end
      prev_stall = Out_Valid && !Out_Ready;
      prev_res   = Result;
      prev_flg   = Flags;
      prev_err   = Op_Err;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      Out_Ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                      input exp_t e);
    logic acc;
    Data_A   = a;
    Data_B   = b;
    Op       = op;
    cur_exp  = e;
    In_Valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      acc = In_Ready;
      @(posedge clock);
      #1;
      if (acc) begin
        In_Valid = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: In_Ready never 1, expected acceptance within 200 cycles");
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    ready_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clock);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(Out_Valid), 32'd0);
    chk({tag, "_result"}, 32'(Result), 32'd0);
    chk({tag, "_flags"}, 32'(Flags), 32'd0);
    chk({tag, "_op_err"}, 32'(Op_Err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;

    vecs[0]  = mk(8'h7F, 8'h01, OP_ADD, 8'h80, 4'b0101, 1'b0);
    vecs[1]  = mk(8'hFF, 8'h01, OP_ADD, 8'h00, 4'b1010, 1'b0);
    vecs[2]  = mk(8'h03, 8'h05, OP_SUB, 8'hFE, 4'b0110, 1'b0);
    vecs[3]  = mk(8'h90, 8'h02, OP_SRA, 8'hE4, 4'b0100, 1'b0);
    vecs[4]  = mk(8'h90, 8'h02, OP_SRL, 8'h24, 4'b0000, 1'b0);
    vecs[5]  = mk(8'h81, 8'h01, OP_SLL, 8'h02, 4'b0000, 1'b0);
    vecs[6]  = mk(8'hFF, 8'h01, OP_SLT, 8'h01, 4'b0000, 1'b0);
    vecs[7]  = mk(8'h81, 8'h09, OP_SLL, 8'h02, 4'b0000, 1'b0);
    vecs[8]  = mk(8'h55, 8'h00, 6'b111111, 8'h00, 4'b1000, 1'b1);
    vecs[9]  = mk(8'h01, 8'h02, OP_ADD, 8'h03, 4'b0000, 1'b0);
    vecs[10] = mk(8'hF0, 8'h3C, OP_AND, 8'h30, 4'b0000, 1'b0);
    vecs[11] = mk(8'h00, 8'h00, OP_NOR, 8'hFF, 4'b0100, 1'b0);
    vecs[12] = mk(8'hAA, 8'hAA, OP_XOR, 8'h00, 4'b1000, 1'b0);
    vecs[13] = mk(8'h80, 8'h01, OP_OR,  8'h81, 4'b0100, 1'b0);
    vecs[14] = mk(8'h80, 8'h01, OP_SUB, 8'h7F, 4'b0001, 1'b0);
    vecs[15] = mk(8'h01, 8'hFF, OP_SLT, 8'h00, 4'b1000, 1'b0);

    op_pool = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
                6'b111111, 6'b000001};

    // Power-on reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("por_in_ready", 32'(In_Ready), 32'd1);
    @(posedge clock);
    #1;

    // Directed vectors, back to back
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    drain();

    // Latency and throughput
    lat_log = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = op_pool[$urandom_range(0, 9)];
      send(a, b, op, ref_model(a, b, op));
    end
    drain();
    lat_log = 1'b0;
    chk("lat_n_in", 32'(in_cycs.size()), 32'd10);
    chk("lat_n_out", 32'(out_cycs.size()), 32'd10);
    if (in_cycs.size() >= 10 && out_cycs.size() >= 10) begin
      chk("latency", 32'(out_cycs[0] - in_cycs[0]), 32'd2);
      chk("in_back_to_back", 32'(in_cycs[9] - in_cycs[0]), 32'd9);
      chk("out_back_to_back", 32'(out_cycs[9] - out_cycs[0]), 32'd9);
    end

    // Random valid/ready traffic
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      while ($urandom_range(0, 1) == 1) begin
        In_Valid = 1'b0;
        Data_A   = 8'($urandom);
        Data_B   = 8'($urandom);
        Op       = 6'($urandom);
        @(posedge clock);
        #1;
      end
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = op_pool[$urandom_range(0, 11)];
      send(a, b, op, ref_model(a, b, op));
    end
    rand_ready = 1'b0;
    drain();

    // Reset with both stages occupied and the sink stalled
    ready_val = 1'b0;
    @(posedge clock);
    #1;
    send(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp);
    send(vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].exp);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("midrst");
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    ready_val = 1'b1;
    @(negedge clock);
    chk("midrst_in_ready", 32'(In_Ready), 32'd1);
    chk("midrst_no_stale", 32'(Out_Valid), 32'd0);
    repeat (6) @(posedge clock);
    #1;
    send(vecs[2].a, vecs[2].b, vecs[2].op, vecs[2].exp);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
